// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_e      - deframer FSM state encoding
//   DataBits         - data bits per frame
//   FrameBits        - total bits per device-to-host frame (start, 8 data, parity, stop)
//   DefFilterLen     - default key_clk glitch-filter length
//   DefTimeoutCycles - default mid-frame watchdog limit (1 ms at 50 MHz)
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned DataBits         = 8;
  localparam int unsigned FrameBits        = 11;
  localparam int unsigned DefFilterLen     = 4;
  localparam int unsigned DefTimeoutCycles = 50000;

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: show-ahead circular FIFO.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write wdata_i (dropped when full unless a pop happens in the same cycle)
//   pop_i        : remove head entry (ignored when empty)
//   rdata_o      : head entry, zero when empty
//   count_o      : occupancy
//   empty_o      : no entries
//   full_o       : Depth entries
module ps2_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rdata_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard receiver feeding a scan-code FIFO.
//   Clk, Rst     : system clock, asynchronous active-high reset
//   key_clk      : raw PS/2 clock (asynchronous)
//   key_data     : raw PS/2 data (asynchronous)
//   rd_en        : pop strobe for the FIFO head
//   clr_err      : clears the sticky flags (wins over a same-cycle set)
//   code_out     : FIFO head byte, 0x00 when empty
//   code_valid   : FIFO non-empty
//   fifo_count   : FIFO occupancy
//   parity_err   : sticky, frame with even parity
//   framing_err  : sticky, bad start/stop bit or mid-frame timeout
//   overflow     : sticky, valid byte dropped on a full FIFO
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = DefFilterLen,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          key_clk,
  input  logic                          key_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    code_out,
  output logic                          code_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overflow
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       BitLast  = 3'(DataBits - 1);

  // Synchronizers reset to the idle line level so reset never fakes an edge.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= key_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= key_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  logic             filt_level_q, filt_level_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  always_comb begin
    filt_level_d = filt_level_q;
    filt_cnt_d   = '0;
    fall         = 1'b0;
    if (clk_s2_q != filt_level_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_level_d = clk_s2_q;
        fall         = filt_level_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Deframer FSM and watchdog.
  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           push, parity_set, framing_set, overflow_set;
  logic           fifo_full;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    wd_d        = wd_q;
    push        = 1'b0;
    parity_set  = 1'b0;
    framing_set = 1'b0;

    if (state_q == StIdle || fall) begin
      wd_d = '0;
    end else if (wd_q == WdLast) begin
      wd_d        = '0;
      state_d     = StIdle;
      framing_set = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            framing_set = 1'b1;
          end
        end
        StData: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!dat_s2_q)              framing_set = 1'b1;
          if (!(^{shift_q, par_q}))   parity_set  = 1'b1;
          push = dat_s2_q && (^{shift_q, par_q});
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign overflow_set = push && fifo_full && !(rd_en && code_valid);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      filt_level_q <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      filt_level_q <= filt_level_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wd_q         <= wd_d;
    end
  end

  // Sticky flags; clr_err wins over a same-cycle set.
  logic parity_err_d, framing_err_d, overflow_d;

  always_comb begin
    parity_err_d  = clr_err ? 1'b0 : (parity_err  | parity_set);
    framing_err_d = clr_err ? 1'b0 : (framing_err | framing_set);
    overflow_d    = clr_err ? 1'b0 : (overflow    | overflow_set);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err  <= parity_err_d;
      framing_err <= framing_err_d;
      overflow    <= overflow_d;
    end
  end

  logic fifo_empty;

  ps2_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DataBits)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .rdata_o (code_out),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign code_valid = !fifo_empty;

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

PS/2 keyboard front end that sits directly upstream of the CPU's keyboard input. It samples the raw `key_clk`/`key_data` lines in the system clock domain, deframes 11-bit device-to-host frames, and checks start, parity and stop bits. Valid scan codes go into a small show-ahead FIFO, which the CPU drains with a one-cycle pop strobe. Error and overflow conditions are reported as sticky flags.

## Interface
- `FIFO_DEPTH`, 8: scan-code FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal synchronized samples required before `key_clk` changes its filtered level.
- `TIMEOUT_CYCLES`, 50000: idle `Clk` cycles mid-frame before the frame is abandoned (1 ms at 50 MHz).
- `Clk`  in  1  system clock; all logic is on its rising edge.
- `Rst`  in  1  reset; **asynchronous, active-high**.
- `key_clk`  in  1  raw PS/2 clock, asynchronous.
- `key_data`  in  1  raw PS/2 data, asynchronous.
- `rd_en`  in  1  pop strobe; ignored when `code_valid`=0.
- `clr_err`  in  1  clears `parity_err`, `framing_err` and `overflow`.
- `code_out`  out  8  FIFO head byte; 0x00 when empty.
- `code_valid`  out  1  FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `parity_err`  out  1  sticky; set by a frame with even total parity.
- `framing_err`  out  1  sticky; set by start=1, stop=0, or a timeout.
- `overflow`  out  1  sticky; set when a valid byte is dropped because the FIFO is full.

## Operation
- Input conditioning: two-flop synchronizer on each line. The filtered `key_clk` level changes only after `FILTER_LEN` consecutive equal synchronized samples. A falling edge of the filtered clock produces a one-cycle `fall` pulse.
- Data sampling: synchronized `key_data` is sampled on each `fall`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA with bit counter = 0. On `fall` with data=1, set `framing_err` and stay in IDLE.
  - DATA: shift the bit into the shift register, LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on `fall`, validate the frame and return to IDLE.
    - Valid frame: XOR of the 8 data bits and the parity bit = 1, and stop = 1.
    - Valid frame: push the byte.
    - Parity fail: set `parity_err`; the byte is discarded.
    - Stop = 0: set `framing_err`; the byte is discarded.
- Timeout: a watchdog counter clears on every `fall` and counts while the FSM is outside IDLE. Reaching `TIMEOUT_CYCLES` returns the FSM to IDLE and sets `framing_err`.
- FIFO: circular buffer with show-ahead output, so `code_out` always shows the head entry.
  - Pop when `rd_en && code_valid`.
  - Push while full with a simultaneous pop: both happen, and `overflow` stays unchanged.
  - Push while full without a pop: the new byte is dropped and `overflow` is set.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `clr_err` has priority over a same-cycle set of any flag; the flags read 0 on the next cycle.
- Reset clears all of the following: synchronizers (to 1, the idle line level), filter, FSM (IDLE), watchdog, FIFO pointers and count, all flags, and `code_out`=0x00.
  - Reset asserted mid-frame discards the partial frame.
  - Reset asserted mid-frame leaves no flag set after release.

## Timing
- Latency from a raw `key_clk` falling edge to `fall`: 2 (sync) + `FILTER_LEN` cycles, ±1.
- The byte is written on the cycle of the stop-bit `fall`. `code_valid` rises on the next `Clk` edge.
- Pop takes effect at the `Clk` edge where `rd_en`=1. The next entry, or 0x00 with `code_valid`=0, is visible after that edge.
- `fifo_count` updates on the same edge as the push or pop that changes it.
- Flags set on the `Clk` edge that detects the error.

## Structure
- Package `ps2_pkg` holds:
  - FSM state encoding (IDLE/DATA/PARITY/STOP).
  - Frame constants: 8 data bits, 11-bit frame length.
  - Default values of `TIMEOUT_CYCLES` and `FILTER_LEN`.
- Sub-module `ps2_fifo` (parameterized by depth and width; show-ahead; handles simultaneous push/pop). It contains the storage, pointers and count.
- The conditioning logic, FSM and watchdog stay in the top module.

## Test plan
- Send frame 0x1C with parity bit 0 -> `code_valid`=1, `code_out`=0x1C, `fifo_count`=1. Assert `rd_en` -> `code_valid`=0, `code_out`=0x00.
- Send 0xF0 then 0x1C, correct parity for each -> FIFO returns 0xF0 first, then 0x1C. No flags set.
- Send 0x1C with parity bit 1 -> `parity_err`=1, `fifo_count`=0. Pulse `clr_err` -> `parity_err`=0.
- Send 9 valid bytes (0x01..0x09) with no pops -> `fifo_count`=8, `overflow`=1, head=0x01, 0x09 lost. Then push with a same-cycle pop at full -> `overflow` unchanged, count stays 8.
- Send start + 4 data bits, then idle for `TIMEOUT_CYCLES`+10 cycles -> `framing_err`=1, FSM back in IDLE. The next full 0x1C frame is received correctly.
- Assert `Rst` mid-frame after 5 bits -> all outputs 0 after release. The following 0x1C frame is received correctly.
